id_hazard_ctrl: RTL and testbench
=================================

// Module: id_hazard_ctrl
// PURPOSE
// - Sequences the instruction-decode stage: holds an in-flight-write scoreboard for the register file and stalls ID on RAW/WAW hazards.
// - Branches compare operands in ID, so no operand forwarding reaches ID; sources must be retired before issue.
// - Issues one-cycle IF flushes on taken branches and keeps a stall-cycle counter with a watchdog.
// - Sits between the ID stage, the IF pipeline register and the WB write port.
// PARAMETERS
// - NUM_REGS      32   architectural registers; x0 never tracked
// - CNT_W         2    per-register pending-write counter width; saturates at 2**CNT_W-1
// - STALL_CNT_W   16   width of the saturating consecutive-stall counter
// - TIMEOUT       64   consecutive stall cycles before hazard_timeout asserts
// PORTS
// - clk             in   1   rising-edge clock
// - reset           in   1   synchronous, active-high reset
// - id_valid        in   1   ID holds a valid instruction
// - id_rs1          in   5   source register 1 (instruction[19:15])
// - id_rs2          in   5   source register 2 (instruction[24:20])
// - id_uses_rs1     in   1   instruction reads rs1
// - id_uses_rs2     in   1   instruction reads rs2
// - id_rd           in   5   destination (instruction[11:7])
// - id_reg_write    in   1   instruction writes rd
// - id_is_branch    in   1   conditional branch / jump resolved in ID
// - id_branch_taken in   1   ID compare result; qualified by id_is_branch
// - wb_reg_write    in   1   WB writes the register file this cycle
// - wb_rd           in   5   WB destination
// - pipe_flush      in   1   later-stage flush; kills the ID instruction
// - id_issue        out  1   ID instruction advances to EX this cycle
// - stall_if        out  1   hold PC and IF/ID register
// - bubble_ex       out  1   insert NOP into ID/EX register
// - flush_if        out  1   invalidate IF/ID register (taken branch)
// - stall_cycles    out  STALL_CNT_W  consecutive stall cycles, saturating
// - hazard_timeout  out  1   sticky; set when stall_cycles reaches TIMEOUT
// BEHAVIOUR
// - Reset: all pending counters 0; FSM RUN; every output 0; stall_cycles 0; hazard_timeout cleared.
// - hazard = id_valid & ((id_uses_rs1 & pend[rs1]!=0) | (id_uses_rs2 & pend[rs2]!=0)
//   | (id_reg_write & rd!=0 & pend[rd]==MAX)); reads of x0 never hazard.
// - id_issue = id_valid & ~hazard & ~pipe_flush & state==RUN; combinational; no registered latency.
// - stall_if = bubble_ex = id_valid & ~id_issue & ~pipe_flush.
// - Scoreboard update, same edge:
//   - On id_issue & id_reg_write & rd!=0: pend[rd]++.
//   - On wb_reg_write & wb_rd!=0: pend[wb_rd]--.
//   - Both on the same register: value unchanged.
//   - Decrement at 0 holds 0 and is a bench error.
// - No WB->ID bypass: a register cleared at WB becomes readable the next cycle.
// - FSM RUN/REDIRECT:
//   - RUN -> REDIRECT when id_issue & id_is_branch & id_branch_taken; flush_if=1 for exactly that cycle.
//   - REDIRECT -> RUN after 1 cycle; id_issue is 0 in REDIRECT (wrong-path slot).
// - A taken branch that is stalled does not flush until the cycle it issues.
// - pipe_flush has priority over everything:
//   - Forces id_issue=0, stall_if=0 and FSM to RUN.
//   - Pending counters are not cleared: older instructions still retire.
// - stall_cycles: +1 each stall_if cycle, cleared on any non-stall cycle, saturates at all-ones.
//   - hazard_timeout sets when stall_cycles==TIMEOUT-1 and stalling; cleared only by reset.
// - Reset asserted mid-stall or mid-REDIRECT: next cycle matches the reset state exactly.
// STRUCTURE
// - Package rv32_pipe_pkg: reg_idx_t (logic [4:0]), PEND_CNT_W, and the fsm state enum {RUN, REDIRECT}.
// - Sub-module id_scoreboard: NUM_REGS counters, inc/dec ports, 3 lookup ports (rs1, rs2, rd) returning nonzero/saturated flags.
// - Top holds the hazard logic, FSM and stall counter.
// TESTING
// - Issue addi x5 (rd=5); next cycle add x6,x5,x1 -> stall_if=1 until WB of x5.
//   - id_issue=1 the cycle after wb_rd=5 retires; stall_cycles shows the stall count.
// - beq issues, taken -> flush_if=1 one cycle, id_issue=0 next cycle, then RUN.
//   - Same branch not taken -> flush_if stays 0.
// - Issue with rd=7 while WB retires rd=7 in the same cycle -> pend[7] unchanged (1->1).
// - Four back-to-back writes to x9, no WB -> fourth stalls (pend=3, saturated) until one WB.
// - Source x0 with id_uses_rs1=1 -> never stalls; writes to x0 never counted.
// - Hold a hazard 64 cycles -> hazard_timeout=1 at cycle 64.
//   - pipe_flush -> stall_if=0 that cycle; reset -> all outputs 0 next cycle.

Source files
------------

// File: rtl/rv32_pipe_pkg.sv
// Shared types for the decode-stage hazard controller: register index,
// pending-write counter width, sequencing states and a small helper.
package rv32_pipe_pkg;

    localparam int REG_IDX_W  = 5;
    localparam int PEND_CNT_W = 2;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // RUN: normal issue. REDIRECT: the slot right after a taken branch,
    // whose fetched instruction is on the wrong path.
    typedef enum logic [0:0] {
        RUN      = 1'b0,
        REDIRECT = 1'b1
    } fsm_state_t;

    // x0 is hard-wired to zero, so it never has an in-flight write.
    function automatic logic is_tracked(input reg_idx_t idx);
        return idx != '0;
    endfunction

endpackage

// File: rtl/id_hazard_ctrl_if.sv
// Signal bundle between the ID stage / WB port (master) and the hazard
// controller (slave).
interface id_hazard_ctrl_if #(
    parameter int STALL_CNT_W = 16
);
    import rv32_pipe_pkg::*;

    // Decode-stage instruction fields
    logic                   id_valid;
    reg_idx_t               id_rs1;
    reg_idx_t               id_rs2;
    logic                   id_uses_rs1;
    logic                   id_uses_rs2;
    reg_idx_t               id_rd;
    logic                   id_reg_write;
    logic                   id_is_branch;
    logic                   id_branch_taken;

    // Write-back retirement and late-stage kill
    logic                   wb_reg_write;
    reg_idx_t               wb_rd;
    logic                   pipe_flush;

    // Pipeline control back to IF/ID/EX
    logic                   id_issue;
    logic                   stall_if;
    logic                   bubble_ex;
    logic                   flush_if;
    logic [STALL_CNT_W-1:0] stall_cycles;
    logic                   hazard_timeout;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output id_rd, id_reg_write, id_is_branch, id_branch_taken,
        output wb_reg_write, wb_rd, pipe_flush,
        input  id_issue, stall_if, bubble_ex, flush_if,
        input  stall_cycles, hazard_timeout
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  id_rd, id_reg_write, id_is_branch, id_branch_taken,
        input  wb_reg_write, wb_rd, pipe_flush,
        output id_issue, stall_if, bubble_ex, flush_if,
        output stall_cycles, hazard_timeout
    );

endinterface

// File: rtl/id_scoreboard.sv
// In-flight write scoreboard: one saturating counter per architectural
// register, bumped when a writer issues and dropped when WB retires it.
// Three combinational lookups serve the two sources and the destination.
module id_scoreboard
    import rv32_pipe_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = PEND_CNT_W
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     inc_en_i,
    input  reg_idx_t inc_idx_i,
    input  logic     dec_en_i,
    input  reg_idx_t dec_idx_i,
    input  reg_idx_t rs1_idx_i,
    input  reg_idx_t rs2_idx_i,
    input  reg_idx_t rd_idx_i,
    output logic     rs1_busy_o,
    output logic     rs2_busy_o,
    output logic     rd_sat_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Flattened view of every counter for the lookup muxes.
    logic [NUM_REGS-1:0][CNT_W-1:0] pend;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                // x0 has no storage; it always reads as "nothing pending".
                assign pend[gi] = '0;
            end else begin : g_track
                logic             inc_hit;
                logic             dec_hit;
                logic [CNT_W-1:0] cnt_q;
                logic [CNT_W-1:0] cnt_d;

                assign inc_hit  = inc_en_i && (inc_idx_i == reg_idx_t'(gi));
                assign dec_hit  = dec_en_i && (dec_idx_i == reg_idx_t'(gi));
                assign pend[gi] = cnt_q;

                // Next count: issue and retire on the same edge cancel out;
                // the counter neither wraps above MAX nor below zero.
                always_comb begin
                    cnt_d = cnt_q;
                    if (inc_hit && !dec_hit) begin
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else if (dec_hit && !inc_hit) begin
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                end

                // Counter register, cleared by reset.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
            end
        end
    endgenerate

    assign rs1_busy_o = (pend[rs1_idx_i] != '0);
    assign rs2_busy_o = (pend[rs2_idx_i] != '0);
    assign rd_sat_o   = (pend[rd_idx_i] == CNT_MAX);

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage sequencer. Branches resolve in ID with no forwarding path,
// so any source with an outstanding write stalls ID until WB retires it.
// A destination whose pending counter is saturated also stalls (WAW).
// Taken branches flush IF for one cycle and the following slot is
// treated as wrong-path. A consecutive-stall counter feeds a sticky
// watchdog flag.
module id_hazard_ctrl
    import rv32_pipe_pkg::*;
#(
    parameter int NUM_REGS    = 32,
    parameter int CNT_W       = PEND_CNT_W,
    parameter int STALL_CNT_W = 16,
    parameter int TIMEOUT     = 64
) (
    input  logic            clk,
    input  logic            reset,
    id_hazard_ctrl_if.slave bus
);

    localparam logic [STALL_CNT_W-1:0] STALL_MAX  = '1;
    localparam logic [STALL_CNT_W-1:0] STALL_ONE  = STALL_CNT_W'(1);
    localparam logic [STALL_CNT_W-1:0] TIMEOUT_M1 = STALL_CNT_W'(TIMEOUT - 1);

    fsm_state_t             state_q;
    fsm_state_t             state_d;
    logic [STALL_CNT_W-1:0] stall_cycles_q;
    logic [STALL_CNT_W-1:0] stall_cycles_d;
    logic                   timeout_q;
    logic                   timeout_d;

    logic rs1_busy;
    logic rs2_busy;
    logic rd_sat;
    logic hazard;
    logic issue;
    logic stall;
    logic redirect_go;
    logic inc_en;
    logic dec_en;

    // A writer issues into the scoreboard only when it really leaves ID;
    // x0 writes are dropped on both sides.
    assign inc_en = issue && bus.id_reg_write && is_tracked(bus.id_rd);
    assign dec_en = bus.wb_reg_write && is_tracked(bus.wb_rd);

    id_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .CNT_W    (CNT_W)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .inc_en_i   (inc_en),
        .inc_idx_i  (bus.id_rd),
        .dec_en_i   (dec_en),
        .dec_idx_i  (bus.wb_rd),
        .rs1_idx_i  (bus.id_rs1),
        .rs2_idx_i  (bus.id_rs2),
        .rd_idx_i   (bus.id_rd),
        .rs1_busy_o (rs1_busy),
        .rs2_busy_o (rs2_busy),
        .rd_sat_o   (rd_sat)
    );

    // RAW on either used source, or WAW when the destination counter is full.
    // WB retirement lands on the edge, so a register freed this cycle is
    // still seen as busy here.
    always_comb begin
        hazard = 1'b0;
        if (bus.id_valid) begin
            hazard = (bus.id_uses_rs1 && rs1_busy)
                  || (bus.id_uses_rs2 && rs2_busy)
                  || (bus.id_reg_write && is_tracked(bus.id_rd) && rd_sat);
        end
    end

    // Sequencing: decides issue and branch redirect; a late flush overrides
    // everything and returns to RUN.
    always_comb begin
        state_d     = state_q;
        issue       = 1'b0;
        redirect_go = 1'b0;
        case (state_q)
            RUN: begin
                issue       = bus.id_valid && !hazard && !bus.pipe_flush;
                redirect_go = issue && bus.id_is_branch && bus.id_branch_taken;
                if (redirect_go) begin
                    state_d = REDIRECT;
                end
            end
            REDIRECT: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        if (bus.pipe_flush) begin
            state_d = RUN;
        end
    end

    assign stall = bus.id_valid && !issue && !bus.pipe_flush;

    // Consecutive-stall count, saturating; watchdog latches on the stall
    // cycle that takes the count to TIMEOUT.
    always_comb begin
        stall_cycles_d = '0;
        timeout_d      = timeout_q;
        if (stall) begin
            stall_cycles_d = (stall_cycles_q == STALL_MAX) ? stall_cycles_q
                                                           : stall_cycles_q + STALL_ONE;
            if (stall_cycles_q == TIMEOUT_M1) begin
                timeout_d = 1'b1;
            end
        end
    end

    // State, stall counter and watchdog registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RUN;
            stall_cycles_q <= '0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            stall_cycles_q <= stall_cycles_d;
            timeout_q      <= timeout_d;
        end
    end

    assign bus.id_issue       = issue;
    assign bus.stall_if       = stall;
    assign bus.bubble_ex      = stall;
    assign bus.flush_if       = redirect_go;
    assign bus.stall_cycles   = stall_cycles_q;
    assign bus.hazard_timeout = timeout_q;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench for id_hazard_ctrl: directed scenarios followed by random traffic,
// all checked against a behavioural model of the decode-stage rules.
module tb_id_hazard_ctrl;
    import rv32_pipe_pkg::*;

    localparam int STALL_CNT_W = 16;
    localparam int TIMEOUT     = 64;
    localparam int PMAX        = 3;
    localparam int SMAX        = 65535;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    id_hazard_ctrl_if #(.STALL_CNT_W(STALL_CNT_W)) bus ();

    id_hazard_ctrl #(
        .NUM_REGS    (32),
        .CNT_W       (2),
        .STALL_CNT_W (STALL_CNT_W),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish, required finish before 2ms");
        $fatal(1);
    end

    // Reference model state
    int pend_m [32];
    bit redirect_m;
    int stall_m;
    bit timeout_m;

    function automatic bit m_hazard();
        return bus.id_valid && ((bus.id_uses_rs1 && pend_m[bus.id_rs1] > 0)
                             || (bus.id_uses_rs2 && pend_m[bus.id_rs2] > 0)
                             || (bus.id_reg_write && bus.id_rd != 0 && pend_m[bus.id_rd] == PMAX));
    endfunction

    function automatic bit m_issue();
        return bus.id_valid && !m_hazard() && !bus.pipe_flush && !redirect_m;
    endfunction

    function automatic bit m_stall();
        return bus.id_valid && !m_issue() && !bus.pipe_flush;
    endfunction

    function automatic bit m_flush();
        return m_issue() && bus.id_is_branch && bus.id_branch_taken;
    endfunction

    task automatic model_advance();
        bit iss, stl, fl;
        iss = m_issue();
        stl = m_stall();
        fl  = m_flush();
        if (reset) begin
            foreach (pend_m[i]) pend_m[i] = 0;
            redirect_m = 0;
            stall_m    = 0;
            timeout_m  = 0;
            return;
        end
        if (iss && bus.id_reg_write && bus.id_rd != 0 && pend_m[bus.id_rd] < PMAX)
            pend_m[bus.id_rd]++;
        if (bus.wb_reg_write && bus.wb_rd != 0) begin
            if (pend_m[bus.wb_rd] == 0) begin
                checks++;
                failures++;
                $display("FAIL bench_wb_underflow reg=%0d pending=0 required>0", bus.wb_rd);
            end else begin
                pend_m[bus.wb_rd]--;
            end
        end
        if (stl && stall_m == TIMEOUT - 1) timeout_m = 1;
        stall_m    = stl ? ((stall_m == SMAX) ? SMAX : stall_m + 1) : 0;
        redirect_m = bus.pipe_flush ? 1'b0 : fl;
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic drive_idle();
        bus.id_valid = 0; bus.id_rs1 = '0; bus.id_rs2 = '0;
        bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0; bus.id_rd = '0;
        bus.id_reg_write = 0; bus.id_is_branch = 0; bus.id_branch_taken = 0;
        bus.wb_reg_write = 0; bus.wb_rd = '0; bus.pipe_flush = 0;
    endtask

    task automatic drive_id(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                            input int rd, input bit w, input bit br, input bit tk);
        bus.id_valid = v; bus.id_rs1 = reg_idx_t'(rs1); bus.id_uses_rs1 = u1;
        bus.id_rs2 = reg_idx_t'(rs2); bus.id_uses_rs2 = u2;
        bus.id_rd = reg_idx_t'(rd); bus.id_reg_write = w;
        bus.id_is_branch = br; bus.id_branch_taken = tk;
    endtask

    task automatic drive_wb(input bit w, input int rd);
        bus.wb_reg_write = w;
        bus.wb_rd = reg_idx_t'(rd);
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1;
        tick();
        tick();
        reset = 0;
        @(negedge clk);
        checks++;
        if ({bus.id_issue, bus.stall_if, bus.bubble_ex, bus.flush_if, bus.hazard_timeout} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs issue/stall/bubble/flush/timeout=%b required 00000",
                     {bus.id_issue, bus.stall_if, bus.bubble_ex, bus.flush_if, bus.hazard_timeout});
        end
        checks++;
        if (bus.stall_cycles !== '0) begin
            failures++;
            $display("FAIL reset_stall_cycles actual=%0d required 0", bus.stall_cycles);
        end
        tick();
    endtask

    task automatic test_raw_stall();
        int k;
        k = $urandom_range(2, 6);
        drive_idle();
        drive_id(1, 0, 1, 0, 0, 5, 1, 0, 0);
        @(negedge clk);
        checks++;
        if (bus.id_issue !== 1'b1) begin
            failures++;
            $display("FAIL raw_addi_issue actual=%b required 1", bus.id_issue);
        end
        tick();
        drive_id(1, 5, 1, 1, 1, 6, 1, 0, 0);
        for (int c = 0; c < k; c++) begin
            if (c == k - 1) drive_wb(1, 5);
            @(negedge clk);
            checks++;
            if ({bus.stall_if, bus.bubble_ex, bus.id_issue} !== 3'b110) begin
                failures++;
                $display("FAIL raw_stall cycle=%0d stall/bubble/issue=%b required 110", c,
                         {bus.stall_if, bus.bubble_ex, bus.id_issue});
            end
            checks++;
            if (bus.stall_cycles !== STALL_CNT_W'(c)) begin
                failures++;
                $display("FAIL raw_stall_count cycle=%0d actual=%0d required %0d", c, bus.stall_cycles, c);
            end
            tick();
        end
        drive_wb(0, 0);
        @(negedge clk);
        checks++;
        if ({bus.id_issue, bus.stall_if} !== 2'b10) begin
            failures++;
            $display("FAIL raw_release issue/stall=%b required 10", {bus.id_issue, bus.stall_if});
        end
        checks++;
        if (bus.stall_cycles !== STALL_CNT_W'(k)) begin
            failures++;
            $display("FAIL raw_total_stalls actual=%0d required %0d", bus.stall_cycles, k);
        end
        tick();
        drive_idle();
        drive_wb(1, 6);
        tick();
        drive_wb(0, 0);
    endtask

    task automatic test_branch();
        // taken branch: flush one cycle, wrong-path slot, then RUN
        drive_idle();
        drive_id(1, 1, 1, 2, 1, 0, 0, 1, 1);
        @(negedge clk);
        checks++;
        if ({bus.id_issue, bus.flush_if} !== 2'b11) begin
            failures++;
            $display("FAIL br_taken issue/flush=%b required 11", {bus.id_issue, bus.flush_if});
        end
        tick();
        drive_id(1, 3, 1, 4, 1, 8, 1, 0, 0);
        @(negedge clk);
        checks++;
        if ({bus.id_issue, bus.flush_if} !== 2'b00) begin
            failures++;
            $display("FAIL br_redirect_slot issue/flush=%b required 00", {bus.id_issue, bus.flush_if});
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.id_issue !== 1'b1) begin
            failures++;
            $display("FAIL br_back_to_run issue=%b required 1", bus.id_issue);
        end
        tick();
        drive_idle();
        drive_wb(1, 8);
        tick();
        drive_wb(0, 0);
        // not-taken branch, twice back to back
        for (int i = 0; i < 2; i++) begin
            drive_id(1, 1, 1, 2, 1, 0, 0, 1, 0);
            @(negedge clk);
            checks++;
            if ({bus.id_issue, bus.flush_if} !== 2'b10) begin
                failures++;
                $display("FAIL br_not_taken iter=%0d issue/flush=%b required 10", i,
                         {bus.id_issue, bus.flush_if});
            end
            tick();
        end
        // taken branch stalled on x3: flush only when it issues
        drive_id(1, 0, 0, 0, 0, 3, 1, 0, 0);
        tick();
        drive_id(1, 3, 1, 2, 1, 0, 0, 1, 1);
        for (int c = 0; c < 2; c++) begin
            if (c == 1) drive_wb(1, 3);
            @(negedge clk);
            checks++;
            if ({bus.flush_if, bus.stall_if} !== 2'b01) begin
                failures++;
                $display("FAIL br_stalled cycle=%0d flush/stall=%b required 01", c,
                         {bus.flush_if, bus.stall_if});
            end
            tick();
        end
        drive_wb(0, 0);
        @(negedge clk);
        checks++;
        if ({bus.id_issue, bus.flush_if} !== 2'b11) begin
            failures++;
            $display("FAIL br_stalled_issue issue/flush=%b required 11", {bus.id_issue, bus.flush_if});
        end
        tick();
        drive_idle();
        tick();
    endtask

    task automatic test_same_reg();
        drive_idle();
        drive_id(1, 0, 0, 0, 0, 7, 1, 0, 0);
        tick();
        drive_wb(1, 7);
        @(negedge clk);
        checks++;
        if (bus.id_issue !== 1'b1) begin
            failures++;
            $display("FAIL same_reg_issue actual=%b required 1", bus.id_issue);
        end
        tick();
        drive_id(1, 7, 1, 0, 0, 0, 0, 0, 0);
        drive_wb(0, 0);
        for (int c = 0; c < 2; c++) begin
            if (c == 1) drive_wb(1, 7);
            @(negedge clk);
            checks++;
            if (bus.stall_if !== 1'b1) begin
                failures++;
                $display("FAIL same_reg_pending cycle=%0d stall_if=%b required 1", c, bus.stall_if);
            end
            tick();
        end
        drive_wb(0, 0);
        @(negedge clk);
        checks++;
        if (bus.id_issue !== 1'b1) begin
            failures++;
            $display("FAIL same_reg_clear issue=%b required 1", bus.id_issue);
        end
        tick();
        drive_idle();
    endtask

    task automatic test_waw_sat();
        drive_idle();
        drive_id(1, 0, 0, 0, 0, 9, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.id_issue !== 1'b1) begin
                failures++;
                $display("FAIL waw_issue write=%0d issue=%b required 1", i, bus.id_issue);
            end
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            if (c == 2) drive_wb(1, 9);
            @(negedge clk);
            checks++;
            if ({bus.stall_if, bus.id_issue} !== 2'b10) begin
                failures++;
                $display("FAIL waw_saturated cycle=%0d stall/issue=%b required 10", c,
                         {bus.stall_if, bus.id_issue});
            end
            tick();
        end
        drive_wb(0, 0);
        @(negedge clk);
        checks++;
        if (bus.id_issue !== 1'b1) begin
            failures++;
            $display("FAIL waw_release issue=%b required 1", bus.id_issue);
        end
        tick();
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            drive_wb(1, 9);
            tick();
        end
        drive_wb(0, 0);
        drive_id(1, 9, 1, 9, 1, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (bus.id_issue !== 1'b1) begin
            failures++;
            $display("FAIL waw_drained issue=%b required 1", bus.id_issue);
        end
        tick();
        drive_idle();
    endtask

    task automatic test_x0();
        drive_idle();
        drive_id(1, 0, 1, 0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.id_issue, bus.stall_if} !== 2'b10) begin
                failures++;
                $display("FAIL x0_never_hazard iter=%0d issue/stall=%b required 10", i,
                         {bus.id_issue, bus.stall_if});
            end
            tick();
        end
        drive_idle();
    endtask

    task automatic test_timeout();
        drive_idle();
        drive_id(1, 0, 0, 0, 0, 12, 1, 0, 0);
        tick();
        drive_id(1, 12, 1, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < TIMEOUT; c++) begin
            @(negedge clk);
            checks++;
            if (bus.hazard_timeout !== 1'b0 || bus.stall_cycles !== STALL_CNT_W'(c)) begin
                failures++;
                $display("FAIL timeout_ramp cycle=%0d timeout=%b count=%0d required 0/%0d", c,
                         bus.hazard_timeout, bus.stall_cycles, c);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (bus.hazard_timeout !== 1'b1 || bus.stall_cycles !== STALL_CNT_W'(TIMEOUT)) begin
            failures++;
            $display("FAIL timeout_set timeout=%b count=%0d required 1/%0d",
                     bus.hazard_timeout, bus.stall_cycles, TIMEOUT);
        end
        tick();
        bus.pipe_flush = 1;
        @(negedge clk);
        checks++;
        if ({bus.stall_if, bus.bubble_ex, bus.id_issue} !== 3'b000) begin
            failures++;
            $display("FAIL flush_kills stall/bubble/issue=%b required 000",
                     {bus.stall_if, bus.bubble_ex, bus.id_issue});
        end
        tick();
        bus.pipe_flush = 0;
        @(negedge clk);
        checks++;
        if (bus.stall_cycles !== '0 || bus.hazard_timeout !== 1'b1 || bus.stall_if !== 1'b1) begin
            failures++;
            $display("FAIL flush_after count=%0d timeout=%b stall=%b required 0/1/1",
                     bus.stall_cycles, bus.hazard_timeout, bus.stall_if);
        end
        tick();
        // reset mid-stall
        reset = 1;
        tick();
        reset = 0;
        drive_idle();
        @(negedge clk);
        checks++;
        if ({bus.id_issue, bus.stall_if, bus.bubble_ex, bus.flush_if, bus.hazard_timeout} !== 5'b0
            || bus.stall_cycles !== '0) begin
            failures++;
            $display("FAIL reset_mid_stall outputs=%b count=%0d required 00000/0",
                     {bus.id_issue, bus.stall_if, bus.bubble_ex, bus.flush_if, bus.hazard_timeout},
                     bus.stall_cycles);
        end
        drive_id(1, 12, 1, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (bus.id_issue !== 1'b1) begin
            failures++;
            $display("FAIL reset_clears_pending issue=%b required 1", bus.id_issue);
        end
        tick();
        // reset mid-redirect
        drive_id(1, 1, 1, 2, 1, 0, 0, 1, 1);
        tick();
        reset = 1;
        drive_idle();
        tick();
        reset = 0;
        drive_id(1, 1, 1, 2, 1, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if ({bus.id_issue, bus.flush_if} !== 2'b10) begin
            failures++;
            $display("FAIL reset_mid_redirect issue/flush=%b required 10", {bus.id_issue, bus.flush_if});
        end
        tick();
        drive_idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            int busy[$];
            busy = {};
            drive_id($urandom_range(0, 9) < 8, $urandom_range(0, 15), $urandom_range(0, 1),
                     $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 15),
                     $urandom_range(0, 1), $urandom_range(0, 4) == 0, $urandom_range(0, 1));
            bus.pipe_flush = ($urandom_range(0, 19) == 0);
            for (int r = 1; r < 32; r++) if (pend_m[r] > 0) busy.push_back(r);
            if (busy.size() > 0 && $urandom_range(0, 1) == 1)
                drive_wb(1, busy[$urandom_range(0, busy.size() - 1)]);
            else if ($urandom_range(0, 7) == 0)
                drive_wb(1, 0);
            else
                drive_wb(0, $urandom_range(0, 15));
            @(negedge clk);
            checks++;
            if ({bus.id_issue, bus.stall_if, bus.bubble_ex, bus.flush_if}
                !== {m_issue(), m_stall(), m_stall(), m_flush()}) begin
                failures++;
                $display("FAIL rand_ctrl n=%0d issue/stall/bubble/flush=%b required %b", n,
                         {bus.id_issue, bus.stall_if, bus.bubble_ex, bus.flush_if},
                         {m_issue(), m_stall(), m_stall(), m_flush()});
            end
            checks++;
            if (bus.stall_cycles !== STALL_CNT_W'(stall_m) || bus.hazard_timeout !== timeout_m) begin
                failures++;
                $display("FAIL rand_counter n=%0d count=%0d timeout=%b required %0d/%b", n,
                         bus.stall_cycles, bus.hazard_timeout, stall_m, timeout_m);
            end
            tick();
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_raw_stall();
        test_branch();
        test_same_reg();
        test_waw_sat();
        test_x0();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
